fetch_stage: RTL



---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_stage_pc_reg.sv | 25 ++
 rtl/fetch_stage.sv | 81 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and the IF/ID pipeline-register layout for the fetch stage.
package fetch_pkg;

    localparam int INSTR_W  = 32;
    localparam int IMEM_AW  = 6;
    localparam int PC_INC   = 4;
    localparam int PC_W_MAX = 64;

    // A flushed IF/ID slot carries this word; consumers must qualify on valid.
    localparam logic [INSTR_W-1:0] BUBBLE = 32'h0;

    // IF/ID contents. The PC field is sized for the widest supported PC and
    // the fetch stage uses only its low N bits.
    typedef struct packed {
        logic [PC_W_MAX-1:0] pc;
        logic [INSTR_W-1:0]  instr;
        logic                valid;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program-counter register: W-bit, synchronous active-high reset, load enable.
module pc_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         srst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Reset clears the register; otherwise it loads only when enabled.
    always_ff @(posedge clk) begin
        if (srst_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, addresses imem, and fills IF/ID.
// Edge priority is reset, then branch redirect, then stall, then normal fetch.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int N     = 64,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               PCSrc,
    input  logic [N-1:0]       PCBranch,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_q,
    output logic [N-1:0]       PC_D,
    output logic [INSTR_W-1:0] instr_D,
    output logic               valid_D,
    output logic [CNT_W-1:0]   fetch_cnt
);

    logic [N-1:0]     pc_q;
    logic [N-1:0]     pc_d;
    logic             pc_en;
    ifid_t            ifid_q;
    ifid_t            ifid_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A redirect always loads the PC, so a stall cannot hold back a branch.
    assign pc_en = PCSrc | ~stall;

    // Branch targets are forced word-aligned; sequential fetch wraps mod 2^N.
    assign pc_d = PCSrc ? {PCBranch[N-1:2], 2'b00} : pc_q + N'(PC_INC);

    pc_reg #(
        .W(N)
    ) u_pc (
        .clk    (clk),
        .srst_i (reset),
        .en_i   (pc_en),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

    // Only PC[7:2] reaches imem, so fetch addresses alias every 256 bytes.
    assign imem_addr = pc_q[IMEM_AW+1:2];

    // IF/ID and counter next-state: flush on redirect, hold on stall, else capture.
    always_comb begin
        ifid_d = ifid_q;
        cnt_d  = cnt_q;
        if (PCSrc) begin
            ifid_d.pc    = '0;
            ifid_d.instr = BUBBLE;
            ifid_d.valid = 1'b0;
        end else if (!stall) begin
            ifid_d.pc    = PC_W_MAX'(pc_q);
            ifid_d.instr = imem_q;
            ifid_d.valid = 1'b1;
            cnt_d        = cnt_q + CNT_W'(1);
        end
    end

    // IF/ID and fetch counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_q <= '0;
            cnt_q  <= '0;
        end else begin
            ifid_q <= ifid_d;
            cnt_q  <= cnt_d;
        end
    end

    assign PC_D      = ifid_q.pc[N-1:0];
    assign instr_D   = ifid_q.instr;
    assign valid_D   = ifid_q.valid;
    assign fetch_cnt = cnt_q;

endmodule
